// File: rtl/clk_rst_sequencer.sv
// clk_rst_sequencer: brings up the IDELAYCTRL and fabric reset after the DCM
// locks. It filters the lock, pulses idelay_rst, waits for idelay_rdy with
// bounded retries, holds user_rst for a settling period and then runs. The
// sequence reruns on rdy loss or soft request, and restarts on lock loss.
// All parameters must be >= 1, except MAX_RETRIES, which is 0..15.
//
// Ports:
//   sys_clk      in   sole clock, rising edge
//   sys_rst_n    in   asynchronous active-low reset
//   sys_clk_lock in   DCM locked (asynchronous, synchronized inside)
//   idelay_rdy   in   IDELAYCTRL ready (asynchronous, synchronized inside)
//   soft_rst_req in   single-cycle request to rerun the sequence
//   idelay_rst   out  active-high IDELAYCTRL reset
//   user_rst     out  active-high fabric reset
//   seq_done     out  high only in RUN
//   seq_fail     out  high only in FAIL
//   retry_cnt    out  rdy timeouts taken in the current attempt
module clk_rst_sequencer #(
  parameter int unsigned LOCK_FILTER      = 8,
  parameter int unsigned RST_PULSE_CYCLES = 16,
  parameter int unsigned RDY_TIMEOUT      = 1024,
  parameter int unsigned MAX_RETRIES      = 3,
  parameter int unsigned HOLD_CYCLES      = 32
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       sys_clk_lock,
  input  logic       idelay_rdy,
  input  logic       soft_rst_req,
  output logic       idelay_rst,
  output logic       user_rst,
  output logic       seq_done,
  output logic       seq_fail,
  output logic [3:0] retry_cnt
);

  localparam int unsigned RETRY_W = 4;
  localparam int unsigned MAX_A   = (LOCK_FILTER > RST_PULSE_CYCLES) ? LOCK_FILTER : RST_PULSE_CYCLES;
  localparam int unsigned MAX_B   = (RDY_TIMEOUT > HOLD_CYCLES) ? RDY_TIMEOUT : HOLD_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  // Terminal values: the transition fires on the cycle the count reaches N.
  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(RDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_MAX);
  localparam logic [RETRY_W-1:0] RETRY_LIM  = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_RST_PULSE = 3'd1,
    S_WAIT_RDY  = 3'd2,
    S_HOLD      = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_e;

  logic               lock_meta_q, lock_s_q;
  logic               rdy_meta_q, rdy_s_q;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc_c;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               idelay_rst_q, idelay_rst_d;
  logic               user_rst_q, user_rst_d;
  logic               seq_done_q, seq_done_d;
  logic               seq_fail_q, seq_fail_d;

  // Two-flop synchronizers for the asynchronous status inputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      rdy_meta_q  <= 1'b0;
      rdy_s_q     <= 1'b0;
    end else begin
      lock_meta_q <= sys_clk_lock;
      lock_s_q    <= lock_meta_q;
      rdy_meta_q  <= idelay_rdy;
      rdy_s_q     <= rdy_meta_q;
    end
  end

  // Shared phase counter, saturating at the largest terminal value.
  assign cnt_inc_c = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

  // State, counter and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_WAIT_LOCK;
      cnt_q        <= '0;
      retry_q      <= '0;
      idelay_rst_q <= 1'b1;
      user_rst_q   <= 1'b1;
      seq_done_q   <= 1'b0;
      seq_fail_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      idelay_rst_q <= idelay_rst_d;
      user_rst_q   <= user_rst_d;
      seq_done_q   <= seq_done_d;
      seq_fail_q   <= seq_fail_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so the
  // registered outputs always match the registered state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;

    if (state_q != S_WAIT_LOCK && !lock_s_q) begin
      // Lock loss outranks every other event.
      state_d = S_WAIT_LOCK;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_WAIT_LOCK: begin
          if (!lock_s_q) begin
            cnt_d = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = S_RST_PULSE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
        S_RST_PULSE: begin
          if (cnt_q == PULSE_LAST) begin
            state_d = S_WAIT_RDY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
        S_WAIT_RDY: begin
          if (rdy_s_q) begin
            state_d = S_HOLD;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_LIM) begin
              state_d = S_FAIL;
            end else begin
              state_d = S_RST_PULSE;
              retry_d = retry_q + RETRY_W'(1);
            end
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
        S_HOLD: begin
          if (!rdy_s_q) begin
            state_d = S_RST_PULSE;
            cnt_d   = '0;
          end else if (cnt_q == HOLD_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
        S_RUN: begin
          if (!rdy_s_q || soft_rst_req) begin
            state_d = S_RST_PULSE;
            cnt_d   = '0;
          end
        end
        S_FAIL: begin
          if (soft_rst_req) begin
            state_d = S_RST_PULSE;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        default: begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
          retry_d = '0;
        end
      endcase
    end

    idelay_rst_d = (state_d == S_WAIT_LOCK) || (state_d == S_RST_PULSE);
    user_rst_d   = (state_d != S_RUN);
    seq_done_d   = (state_d == S_RUN);
    seq_fail_d   = (state_d == S_FAIL);
  end

  assign idelay_rst = idelay_rst_q;
  assign user_rst   = user_rst_q;
  assign seq_done   = seq_done_q;
  assign seq_fail   = seq_fail_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Bench for clk_rst_sequencer (LOCK_FILTER=4, RST_PULSE_CYCLES=4,
// RDY_TIMEOUT=16, MAX_RETRIES=2, HOLD_CYCLES=8). Stimulus pushes each expected
// output change (value and cycle) into a queue; the monitor pops one entry
// whenever the outputs change or reset is asserted.
module tb_clk_rst_sequencer;

  // {idelay_rst, user_rst, seq_done, seq_fail, retry_cnt}
  localparam logic [7:0] O_RST   = 8'b1100_0000;
  localparam logic [7:0] O_RDY   = 8'b0100_0000;
  localparam logic [7:0] O_RUN   = 8'b0010_0000;
  localparam logic [7:0] O_PLS1  = 8'b1100_0001;
  localparam logic [7:0] O_RDY1  = 8'b0100_0001;
  localparam logic [7:0] O_PLS2  = 8'b1100_0010;
  localparam logic [7:0] O_RDY2  = 8'b0100_0010;
  localparam logic [7:0] O_FAIL2 = 8'b0101_0010;

  typedef struct {
    int         cyc;
    logic [7:0] val;
    string      name;
  } exp_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       sys_clk_lock = 1'b0;
  logic       idelay_rdy = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       idelay_rst, user_rst, seq_done, seq_fail;
  logic [3:0] retry_cnt;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic       done = 1'b0;
  logic [7:0] mon_out;
  logic [7:0] mon_prev = 8'hxx;
  logic       mon_prev_rst = 1'b1;
  exp_t       mon_e;

  clk_rst_sequencer #(
    .LOCK_FILTER     (4),
    .RST_PULSE_CYCLES(4),
    .RDY_TIMEOUT     (16),
    .MAX_RETRIES     (2),
    .HOLD_CYCLES     (8)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .sys_clk_lock(sys_clk_lock),
    .idelay_rdy  (idelay_rdy),
    .soft_rst_req(soft_rst_req),
    .idelay_rst  (idelay_rst),
    .user_rst    (user_rst),
    .seq_done    (seq_done),
    .seq_fail    (seq_fail),
    .retry_cnt   (retry_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [7:0] v, input string n);
    exp_t e;
    e.cyc  = c;
    e.val  = v;
    e.name = n;
    exp_q.push_back(e);
  endtask

  // Advance to 1 time unit after the given posedge count.
  task automatic goto(input int target);
    while (cyc < target) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge sys_clk) begin
    mon_out = {idelay_rst, user_rst, seq_done, seq_fail, retry_cnt};
    if (mon_out !== mon_prev || (mon_prev_rst && !sys_rst_n)) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got %b at cycle %0d, required no change", mon_out, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_out !== mon_e.val || (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
          n_fail++;
          $display("FAIL %s: got %b at cycle %0d, required %b at cycle %0d",
                   mon_e.name, mon_out, cyc, mon_e.val, mon_e.cyc);
        end
      end
    end
    mon_prev     = mon_out;
    mon_prev_rst = sys_rst_n;
    if (done) begin
      n_tests++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL missing_events: %0d expected changes never seen, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    int p, r, s, f, l, m;

    push(-1, O_RST, "reset_state");
    goto(3);
    sys_rst_n = 1'b1;

    // Lock glitch: 3 synchronized highs, one low, then steady high.
    p = 5;
    push(p + 14, O_RDY, "glitch_pulse_end");
    push(p + 30, O_RUN, "glitch_run");
    goto(p);      sys_clk_lock = 1'b1;
    goto(p + 3);  sys_clk_lock = 1'b0;
    goto(p + 4);  sys_clk_lock = 1'b1;
    goto(p + 19); idelay_rdy = 1'b1;

    // rdy loss in RUN, then recovery.
    r = p + 35;
    push(r + 3,  O_RST, "rdyloss_pulse_start");
    push(r + 7,  O_RDY, "rdyloss_pulse_end");
    push(r + 20, O_RUN, "rdyloss_run");
    goto(r);     idelay_rdy = 1'b0;
    goto(r + 9); idelay_rdy = 1'b1;

    // rdy never returns: three pulses, retries 1 and 2, then FAIL.
    // soft_rst_req pulses in WAIT_RDY and RST_PULSE must be ignored.
    s = r + 25;
    push(s + 3,  O_RST,   "to_pulse0_start");
    push(s + 7,  O_RDY,   "to_pulse0_end");
    push(s + 23, O_PLS1,  "to_pulse1_start");
    push(s + 27, O_RDY1,  "to_pulse1_end");
    push(s + 43, O_PLS2,  "to_pulse2_start");
    push(s + 47, O_RDY2,  "to_pulse2_end");
    push(s + 63, O_FAIL2, "to_fail");
    goto(s);      idelay_rdy = 1'b0;
    goto(s + 10); soft_rst_req = 1'b1;
    goto(s + 11); soft_rst_req = 1'b0;
    goto(s + 24); soft_rst_req = 1'b1;
    goto(s + 25); soft_rst_req = 1'b0;

    // soft_rst_req leaves FAIL with a fresh pulse.
    f = s + 66;
    push(f + 1,  O_RST, "fail_soft_pulse_start");
    push(f + 5,  O_RDY, "fail_soft_pulse_end");
    push(f + 17, O_RUN, "fail_soft_run");
    goto(f);     soft_rst_req = 1'b1;
    goto(f + 1); soft_rst_req = 1'b0;
    goto(f + 6); idelay_rdy = 1'b1;

    // Lock loss seen in the same cycle as soft_rst_req; then clean nominal.
    l = f + 20;
    push(l + 3,  O_RST, "lockloss_wait_lock");
    push(l + 20, O_RDY, "nominal_pulse_end");
    push(l + 36, O_RUN, "nominal_run");
    goto(l);      sys_clk_lock = 1'b0;
    goto(l + 1);  idelay_rdy = 1'b0;
    goto(l + 2);  soft_rst_req = 1'b1;
    goto(l + 3);  soft_rst_req = 1'b0;
    goto(l + 10); sys_clk_lock = 1'b1;
    goto(l + 25); idelay_rdy = 1'b1;

    // Reset in cycle 2 of a soft-requested pulse; full sequence follows.
    m = l + 40;
    push(m + 1,  O_RST, "soft_run_pulse_start");
    push(m + 2,  O_RST, "midpulse_reset");
    push(m + 14, O_RDY, "post_reset_pulse_end");
    push(m + 23, O_RUN, "post_reset_run");
    goto(m);     soft_rst_req = 1'b1;
    goto(m + 1); soft_rst_req = 1'b0;
    goto(m + 2); sys_rst_n = 1'b0;
    goto(m + 4); sys_rst_n = 1'b1;
    goto(m + 30);
    done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion by time 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
